io_strobe_ctrl: RTL and testbench
=================================

# io_strobe_ctrl

Registered, parametrised I/O bus strobe controller that generalises the four-slot, eight-register read/write address decode. It accepts one bus request at a time and decodes the slot and register fields to a single one-hot read or write strobe. It holds that strobe for a programmable number of wait states, then returns an acknowledge. It sits between the engine's bus master and the peripheral register slots, and it flags malformed or out-of-range requests instead of silently dropping them.

## Interface
- SLOTS, 4, number of peripheral slots (1..16; need not be a power of two)
- REGS, 8, registers per slot (power of two, 2..64)
- WAIT, 2, extra cycles the strobe is held beyond the first (0..15)
- SLOT_W, clog2(SLOTS) (min 1), derived width of the slot field
- REG_W, clog2(REGS), derived width of the register field
- CLK  in  1  single clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- REQ  in  1  request valid; sampled only when BUSY=0
- ADDR  in  SLOT_W+REG_W  {slot, reg}; upper SLOT_W bits select slot, lower REG_W bits select register
- READ  in  1  read request qualifier
- WRITE  in  1  write request qualifier
- BUSY  out  1  transaction in progress; REQ ignored while high
- ACK  out  1  one-cycle completion pulse
- ERR  out  1  one-cycle error pulse, coincident with ACK
- READS  out  SLOTS*REGS  one-hot read strobes; slot s, register r drives bit s*REGS+r
- WRITES  out  SLOTS*REGS  one-hot write strobes, same bit mapping

## Operation
- Reset (RESET_N=0): all outputs go to 0 immediately. FSM returns to IDLE, wait counter and captured request are cleared. Reset asserted mid-transaction kills the strobe asynchronously and produces no ACK.
- FSM states: IDLE, STROBE, DONE.
- IDLE, REQ=1: capture ADDR, READ and WRITE.
  - Malformed request: READ and WRITE both 1, both 0, or slot field >= SLOTS. Next state is DONE with the error flag set.
  - Valid request: next state is STROBE, counter loads WAIT.
- STROBE:
  - Exactly one bit of READS (READ) or WRITES (WRITE) is high, at index slot*REGS+reg.
  - Counter decrements each cycle. When the counter is 0, next state is DONE.
- DONE:
  - All strobes are 0.
  - ACK=1. ERR=1 only for an errored request; no strobe was ever asserted for it.
  - Next state is always IDLE.
- REQ in IDLE is accepted whatever its previous value (level-sensitive). REQ while BUSY=1 is ignored, not queued.
- ADDR, READ and WRITE may change freely after capture. Strobe indices come from the captured values only.
- All outputs are registered; no combinational path from inputs to outputs.
- READS and WRITES are never both nonzero, and each is never more than one-hot.

## Timing
- Cycle 0: REQ sampled high in IDLE.
- Valid request:
  - Cycles 1..WAIT+1: strobe high, WAIT+1 cycles total.
  - Cycle WAIT+2: ACK=1.
  - BUSY=1 in cycles 1..WAIT+2.
  - Earliest next acceptance is cycle WAIT+3, giving a throughput of one request per WAIT+3 cycles.
- Errored request:
  - Cycle 1: ACK=1, ERR=1, BUSY=1.
  - Next acceptance is cycle 2.
- WAIT=0: strobe lasts exactly one cycle and ACK follows in cycle 2.
- Reset release takes effect synchronously: the first REQ can be sampled on the first rising edge after RESET_N deasserts.

## Test plan
- Defaults (SLOTS=4, REGS=8, WAIT=2). REQ=1, ADDR=5'b10101, READ=1, WRITE=0 -> READS bit 21 high in cycles 1-3, WRITES=0, ACK in cycle 4 with ERR=0, BUSY high in cycles 1-4.
- Defaults. Write to ADDR=5'b00000, then write to ADDR=5'b11111 with REQ held high -> WRITES bit 0 high for 3 cycles, then WRITES bit 31 high for 3 cycles starting in cycle 6. REQ was ignored while busy.
- Defaults. REQ with READ=1 and WRITE=1, then REQ with READ=0 and WRITE=0 -> each produces ACK=1 and ERR=1 in cycle 1, no strobe bit ever high, BUSY low in cycle 2.
- SLOTS=3, REGS=4, WAIT=0. ADDR=4'b1110, READ=1 -> ERR pulse with no strobe. ADDR=4'b1011, READ=1 -> READS bit 11 high for exactly cycle 1, ACK in cycle 2.
- Defaults. RESET_N pulled low in cycle 2 of a write to ADDR=5'b01010 -> WRITES bit 10 drops immediately, no ACK. After release, a new read to ADDR=5'b01010 completes normally.
- Randomised long run, all parameter sets -> at most one strobe bit high at any time; every accepted request yields exactly one ACK; strobe length equals WAIT+1.

Source files
------------

// File: rtl/io_strobe_ctrl.sv
// Bus strobe controller: decodes one {slot, reg} request into a one-hot read or write
// strobe, holds it for WAIT extra cycles, then acknowledges (or flags a malformed request).
module io_strobe_ctrl #(
  parameter int unsigned SLOTS  = 4,
  parameter int unsigned REGS   = 8,
  parameter int unsigned WAIT   = 2,
  localparam int unsigned SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  localparam int unsigned REG_W  = $clog2(REGS),
  localparam int unsigned AW     = SLOT_W + REG_W,
  localparam int unsigned N      = SLOTS * REGS
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req,
  input  logic [AW-1:0] addr,
  input  logic          read,
  input  logic          write,
  output logic          busy,
  output logic          ack,
  output logic          err,
  output logic [N-1:0]  reads,
  output logic [N-1:0]  writes
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StStrobe = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rd_q, rd_d;
  logic          bad_q, bad_d;
  logic [N-1:0]  onehot_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    bad_d   = bad_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          addr_d  = addr;
          rd_d    = read;
          // Both or neither qualifier, or a slot beyond the populated range, is an error.
          bad_d   = (read == write) || (32'(addr[AW-1:REG_W]) >= SLOTS);
          cnt_d   = 4'(WAIT);
          state_d = bad_d ? StDone : StStrobe;
        end
      end
      StStrobe: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // REGS is a power of two, so slot*REGS+reg is simply the captured {slot, reg} value.
  always_comb begin
    onehot_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      onehot_d[i] = (addr_d == AW'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      bad_q   <= bad_d;
    end
  end

  // Outputs are registered from next-state values so they line up with state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy   <= 1'b0;
      ack    <= 1'b0;
      err    <= 1'b0;
      reads  <= '0;
      writes <= '0;
    end else begin
      busy   <= (state_d != StIdle);
      ack    <= (state_d == StDone);
      err    <= (state_d == StDone) && bad_d;
      reads  <= ((state_d == StStrobe) && rd_d)  ? onehot_d : '0;
      writes <= ((state_d == StStrobe) && !rd_d) ? onehot_d : '0;
    end
  end

endmodule

// File: tb/tb_io_strobe_ctrl.sv
// Directed bench for io_strobe_ctrl: default parameters plus a SLOTS=3/REGS=4/WAIT=0 instance.
module tb_io_strobe_ctrl;

  logic clk = 1'b0;
  logic reset_n;

  logic        req, read, write;
  logic [4:0]  addr;
  logic        busy, ack, err;
  logic [31:0] reads, writes;

  logic        s_req, s_read, s_write;
  logic [3:0]  s_addr;
  logic        s_busy, s_ack, s_err;
  logic [11:0] s_reads, s_writes;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  io_strobe_ctrl dut (
    .clk    (clk),
    .reset_n(reset_n),
    .req    (req),
    .addr   (addr),
    .read   (read),
    .write  (write),
    .busy   (busy),
    .ack    (ack),
    .err    (err),
    .reads  (reads),
    .writes (writes)
  );

  io_strobe_ctrl #(.SLOTS(3), .REGS(4), .WAIT(0)) dut_s (
    .clk    (clk),
    .reset_n(reset_n),
    .req    (s_req),
    .addr   (s_addr),
    .read   (s_read),
    .write  (s_write),
    .busy   (s_busy),
    .ack    (s_ack),
    .err    (s_err),
    .reads  (s_reads),
    .writes (s_writes)
  );

  // Strobe invariants on both instances, every cycle out of reset.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      n_cmp++;
      if (!($onehot0(reads) && $onehot0(writes) && !(|reads && |writes))) begin
        n_bad++;
        $display("FAIL onehot_dflt reads=%h writes=%h required at most one strobe bit", reads, writes);
      end
      n_cmp++;
      if (!($onehot0(s_reads) && $onehot0(s_writes) && !(|s_reads && |s_writes))) begin
        n_bad++;
        $display("FAIL onehot_small reads=%h writes=%h required at most one strobe bit",
                 s_reads, s_writes);
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b1;
    req = 0; read = 0; write = 0; addr = '0;
    s_req = 0; s_read = 0; s_write = 0; s_addr = '0;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, ack, err, reads, writes} !== 67'd0) begin
      n_bad++;
      $display("FAIL reset_dflt got=%h required 0", {busy, ack, err, reads, writes});
    end
    n_cmp++;
    if ({s_busy, s_ack, s_err, s_reads, s_writes} !== 27'd0) begin
      n_bad++;
      $display("FAIL reset_small got=%h required 0", {s_busy, s_ack, s_err, s_reads, s_writes});
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, ack, err, reads, writes} !== 67'd0) begin
      n_bad++;
      $display("FAIL idle_after_reset got=%h required 0", {busy, ack, err, reads, writes});
    end
  endtask

  task automatic test_read();
    logic [31:0] er;
    logic [2:0]  ebae;
    @(negedge clk);
    req = 1; addr = 5'b10101; read = 1; write = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      req = 0;
      er   = (c <= 3) ? (32'd1 << 21) : 32'd0;
      ebae = (c <= 3) ? 3'b100 : (c == 4) ? 3'b110 : 3'b000;
      n_cmp++;
      if (reads !== er || writes !== 32'd0) begin
        n_bad++;
        $display("FAIL read_strobe c=%0d reads=%h writes=%h required reads=%h writes=0",
                 c, reads, writes, er);
      end
      n_cmp++;
      if ({busy, ack, err} !== ebae) begin
        n_bad++;
        $display("FAIL read_ctl c=%0d busy/ack/err=%b required %b", c, {busy, ack, err}, ebae);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ew;
    logic [2:0]  ebae;
    @(negedge clk);
    req = 1; addr = 5'b00000; read = 0; write = 1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      addr = 5'b11111;
      if (c == 6) req = 0;
      ew   = (c <= 3) ? 32'd1 : (c >= 6 && c <= 8) ? (32'd1 << 31) : 32'd0;
      ebae = (c == 4 || c == 9) ? 3'b110 : (c == 5 || c == 10) ? 3'b000 : 3'b100;
      n_cmp++;
      if (writes !== ew || reads !== 32'd0) begin
        n_bad++;
        $display("FAIL b2b_strobe c=%0d writes=%h reads=%h required writes=%h reads=0",
                 c, writes, reads, ew);
      end
      n_cmp++;
      if ({busy, ack, err} !== ebae) begin
        n_bad++;
        $display("FAIL b2b_ctl c=%0d busy/ack/err=%b required %b", c, {busy, ack, err}, ebae);
      end
    end
  endtask

  task automatic test_errors();
    @(negedge clk);
    req = 1; addr = 5'b00011; read = 1; write = 1;
    @(negedge clk);
    req = 0; read = 0; write = 0;
    n_cmp++;
    if ({busy, ack, err, reads, writes} !== {3'b111, 64'd0}) begin
      n_bad++;
      $display("FAIL err_both busy/ack/err=%b strobes=%h required 111 and 0",
               {busy, ack, err}, {reads, writes});
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL err_both_idle busy=%b required 0", busy);
    end
    req = 1;
    @(negedge clk);
    req = 0;
    n_cmp++;
    if ({busy, ack, err, reads, writes} !== {3'b111, 64'd0}) begin
      n_bad++;
      $display("FAIL err_none busy/ack/err=%b strobes=%h required 111 and 0",
               {busy, ack, err}, {reads, writes});
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, ack, err} !== 3'b000) begin
      n_bad++;
      $display("FAIL err_none_idle busy/ack/err=%b required 000", {busy, ack, err});
    end
  endtask

  task automatic test_small_params();
    @(negedge clk);
    s_req = 1; s_addr = 4'b1110; s_read = 1; s_write = 0;
    @(negedge clk);
    s_req = 0;
    n_cmp++;
    if ({s_busy, s_ack, s_err, s_reads, s_writes} !== {3'b111, 24'd0}) begin
      n_bad++;
      $display("FAIL small_badslot busy/ack/err=%b strobes=%h required 111 and 0",
               {s_busy, s_ack, s_err}, {s_reads, s_writes});
    end
    @(negedge clk);
    s_req = 1; s_addr = 4'b1011; s_read = 1; s_write = 0;
    @(negedge clk);
    s_req = 0;
    n_cmp++;
    if ({s_busy, s_ack, s_err, s_reads, s_writes} !== {3'b100, 12'h800, 12'h000}) begin
      n_bad++;
      $display("FAIL small_read_c1 busy/ack/err=%b reads=%h writes=%h required 100 800 000",
               {s_busy, s_ack, s_err}, s_reads, s_writes);
    end
    @(negedge clk);
    n_cmp++;
    if ({s_busy, s_ack, s_err, s_reads, s_writes} !== {3'b110, 24'd0}) begin
      n_bad++;
      $display("FAIL small_read_c2 busy/ack/err=%b strobes=%h required 110 and 0",
               {s_busy, s_ack, s_err}, {s_reads, s_writes});
    end
    @(negedge clk);
    n_cmp++;
    if (s_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL small_read_c3 busy=%b required 0", s_busy);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req = 1; addr = 5'b01010; read = 0; write = 1;
    @(negedge clk);
    req = 0;
    n_cmp++;
    if (writes !== (32'd1 << 10)) begin
      n_bad++;
      $display("FAIL rst_mid_c1 writes=%h required %h", writes, 32'd1 << 10);
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, ack, err, reads, writes} !== 67'd0) begin
      n_bad++;
      $display("FAIL rst_mid_kill got=%h required 0", {busy, ack, err, reads, writes});
    end
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (ack !== 1'b0 || writes !== 32'd0) begin
        n_bad++;
        $display("FAIL rst_mid_noack ack=%b writes=%h required 0 0", ack, writes);
      end
    end
    reset_n = 1'b1;
    req = 1; addr = 5'b01010; read = 1; write = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      req = 0;
      n_cmp++;
      if (reads !== ((c <= 3) ? (32'd1 << 10) : 32'd0) || ack !== (c == 4) || err !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_after_read c=%0d reads=%h ack=%b err=%b required reads=%h ack=%b err=0",
                 c, reads, ack, err, (c <= 3) ? (32'd1 << 10) : 32'd0, c == 4);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] a;
    logic       r, w, bad;
    int         strobes, acks, errs;
    for (int k = 0; k < 30; k++) begin
      a = 5'($urandom);
      r = 1'($urandom);
      w = 1'($urandom);
      if ($urandom_range(0, 3) != 0) w = ~r;
      bad = (r == w);
      @(negedge clk);
      req = 1; addr = a; read = r; write = w;
      strobes = 0; acks = 0; errs = 0;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        if (!bad && r && reads === (32'd1 << a) && writes === 32'd0) strobes++;
        if (!bad && w && writes === (32'd1 << a) && reads === 32'd0) strobes++;
        if (ack === 1'b1) begin
          acks++;
          if (err === 1'b1) errs++;
        end
        // Inputs are scrambled after capture; the strobe must not follow them.
        req = 0; addr = 5'($urandom); read = 1'($urandom); write = 1'($urandom);
      end
      n_cmp++;
      if (strobes != (bad ? 0 : 3) || acks != 1 || errs != int'(bad)) begin
        n_bad++;
        $display("FAIL random k=%0d a=%0d r=%b w=%b strobes=%0d acks=%0d errs=%0d required %0d 1 %0d",
                 k, a, r, w, strobes, acks, errs, bad ? 0 : 3, int'(bad));
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_back_to_back();
    test_errors();
    test_small_params();
    test_reset_mid();
    test_random();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
